time_hour: RTL and testbench

//   Hour stage of the digital clock; sits directly downstream of the minutes stage.
//   - Consumes the one-cycle minute-rollover strobe.
//   - Counts hours 0..HOURS_PER_DAY-1 and emits a one-cycle day-rollover strobe.
//   - Produces a registered BCD display value in 24h or 12h (AM/PM) format.
//   - Accepts a user hour-set request through a req/ack handshake.

---
 rtl/time_hour.sv | 165 ++++++++++++++++
 tb/tb_time_hour.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/time_hour.sv
// Hour stage of the digital clock: counts hours on minute rollovers, takes hour-set
// requests over a req/ack handshake and drives a registered 24h/12h BCD display.
module time_hour #(
    parameter int HOURS_PER_DAY = 24,
    parameter int HW            = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          minute_tick,
    input  logic          mode_12h,
    input  logic          set_req,
    input  logic [HW-1:0] set_hour,
    output logic          set_ack,
    output logic          set_err,
    output logic [HW-1:0] hour_counter,
    output logic [7:0]    hour_bcd,
    output logic          pm,
    output logic          day
);

    localparam logic [HW:0]   HOUR_LIM = (HW+1)'(HOURS_PER_DAY);
    localparam logic [HW-1:0] HOUR_MAX = HW'(HOURS_PER_DAY - 1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_REL = 1'b1
    } set_state_t;

    set_state_t    state_r;
    set_state_t    state_nxt_s;
    logic          load_s;
    logic          err_s;
    logic [HW-1:0] hour_counter_r;
    logic [HW-1:0] hour_nxt_s;
    logic          day_nxt_s;
    logic          day_r;
    logic          set_ack_r;
    logic          set_err_r;
    logic [7:0]    hour_bcd_r;
    logic          pm_r;
    logic [7:0]    hour8_s;
    logic [7:0]    disp_s;

    // Binary 0..23 to two-digit BCD; tens digit is limited to 0..2.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        if (v >= 8'd20) begin
            tens  = 4'd2;
            units = 4'(v - 8'd20);
        end else if (v >= 8'd10) begin
            tens  = 4'd1;
            units = 4'(v - 8'd10);
        end else begin
            tens  = 4'd0;
            units = 4'(v);
        end
        return {tens, units};
    endfunction

    // Set-handshake state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Set-handshake next state; a held request is served once, then waits for release.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (set_req) begin
                    if ({1'b0, set_hour} < HOUR_LIM) begin
                        load_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                    state_nxt_s = ST_WAIT_REL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_REL: begin
                if (!set_req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_REL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Counter next value; a load overrides and swallows a coincident tick.
    always_comb begin
        hour_nxt_s = hour_counter_r;
        day_nxt_s  = 1'b0;
        if (load_s) begin
            hour_nxt_s = set_hour;
        end else if (minute_tick) begin
            if (hour_counter_r == HOUR_MAX) begin
                hour_nxt_s = '0;
                day_nxt_s  = 1'b1;
            end else begin
                hour_nxt_s = hour_counter_r + HW'(1);
            end
        end else begin
            hour_nxt_s = hour_counter_r;
        end
    end

    // Display value selection: 12h format shows hour 0 and 12 as 12.
    always_comb begin
        hour8_s = 8'(hour_counter_r);
        disp_s  = hour8_s;
        if (mode_12h) begin
            if (hour8_s >= 8'd12) begin
                disp_s = hour8_s - 8'd12;
            end else begin
                disp_s = hour8_s;
            end
            if (disp_s == 8'd0) begin
                disp_s = 8'd12;
            end else begin
                disp_s = disp_s;
            end
        end else begin
            disp_s = hour8_s;
        end
    end

    // Counter, strobes and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hour_counter_r <= '0;
            day_r          <= 1'b0;
            set_ack_r      <= 1'b0;
            set_err_r      <= 1'b0;
            hour_bcd_r     <= 8'h00;
            pm_r           <= 1'b0;
        end else begin
            hour_counter_r <= hour_nxt_s;
            day_r          <= day_nxt_s;
            set_ack_r      <= load_s;
            set_err_r      <= err_s;
            hour_bcd_r     <= to_bcd(disp_s);
            pm_r           <= (hour8_s >= 8'd12);
        end
    end

    assign hour_counter = hour_counter_r;
    assign day          = day_r;
    assign set_ack      = set_ack_r;
    assign set_err      = set_err_r;
    assign hour_bcd     = hour_bcd_r;
    assign pm           = pm_r;

endmodule

// File: tb/tb_time_hour.sv
// Self-checking bench for time_hour: directed scenarios plus randomized traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_time_hour;

    logic       clk;
    logic       rst;
    logic       minute_tick;
    logic       mode_12h;
    logic       set_req;
    logic [4:0] set_hour;
    logic       set_ack;
    logic       set_err;
    logic [4:0] hour_counter;
    logic [7:0] hour_bcd;
    logic       pm;
    logic       day;

    int n_cmp = 0;
    int n_err = 0;
    int m_hour = 0;
    bit m_wait = 1'b0;
    int ack_cnt = 0;
    int err_cnt = 0;

    time_hour #(.HOURS_PER_DAY(24), .HW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .minute_tick  (minute_tick),
        .mode_12h     (mode_12h),
        .set_req      (set_req),
        .set_hour     (set_hour),
        .set_ack      (set_ack),
        .set_err      (set_err),
        .hour_counter (hour_counter),
        .hour_bcd     (hour_bcd),
        .pm           (pm),
        .day          (day)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_bcd(input int h, input logic m);
        int d;
        d = m ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
        return 8'((d / 10) * 16 + (d % 10));
    endfunction

    // One clock cycle: drive inputs, advance the model, compare every output.
    task automatic step(input logic tick, input logic req, input logic [4:0] sh);
        int   old_h;
        bit   loaded;
        logic e_ack, e_err, e_day;
        logic [7:0] e_bcd;
        logic e_pm;
        @(negedge clk);
        minute_tick = tick;
        set_req     = req;
        set_hour    = sh;
        old_h  = m_hour;
        loaded = 1'b0;
        e_ack  = 1'b0;
        e_err  = 1'b0;
        e_day  = 1'b0;
        if (!m_wait && req) begin
            m_wait = 1'b1;
            if (int'(sh) < 24) begin
                e_ack  = 1'b1;
                m_hour = int'(sh);
                loaded = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end else if (m_wait && !req) begin
            m_wait = 1'b0;
        end
        if (!loaded && tick) begin
            if (m_hour == 23) e_day = 1'b1;
            m_hour = (m_hour + 1) % 24;
        end
        e_bcd = exp_bcd(old_h, mode_12h);
        e_pm  = (old_h >= 12);
        @(posedge clk);
        #1;
        if (set_ack) ack_cnt++;
        if (set_err) err_cnt++;
        chk("hour_counter", 32'(hour_counter), 32'(m_hour));
        chk("day", 32'(day), 32'(e_day));
        chk("set_ack", 32'(set_ack), 32'(e_ack));
        chk("set_err", 32'(set_err), 32'(e_err));
        chk("hour_bcd", 32'(hour_bcd), 32'(e_bcd));
        chk("pm", 32'(pm), 32'(e_pm));
    endtask

    logic [4:0] tbl_h   [4] = '{5'd0, 5'd12, 5'd13, 5'd23};
    logic [7:0] tbl_bcd [4] = '{8'h12, 8'h12, 8'h01, 8'h11};
    logic       tbl_pm  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int day_cnt;
        rst         = 1'b0;
        minute_tick = 1'b0;
        mode_12h    = 1'b0;
        set_req     = 1'b0;
        set_hour    = 5'd0;
        #12;
        chk("rst_hour", 32'(hour_counter), 32'd0);
        chk("rst_bcd", 32'(hour_bcd), 32'h00);
        chk("rst_day", 32'(day), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 24 ticks in 24h mode: full day with a single day strobe.
        day_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0, 5'd0);
            if (day) day_cnt++;
        end
        chk("t1_day_count", 32'(day_cnt), 32'd1);
        chk("t1_wrap_day", 32'(day), 32'd1);
        step(1'b0, 1'b0, 5'd0);
        chk("t1_bcd_end", 32'(hour_bcd), 32'h00);

        // 12h sweep plus fixed mapping table.
        mode_12h = 1'b1;
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, tbl_h[i]);
            step(1'b0, 1'b0, 5'd0);
            chk("t2_bcd", 32'(hour_bcd), 32'(tbl_bcd[i]));
            chk("t2_pm", 32'(pm), 32'(tbl_pm[i]));
        end

        // Held request loads once.
        ack_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 5'd17);
        step(1'b0, 1'b0, 5'd0);
        chk("t3_acks", 32'(ack_cnt), 32'd1);
        chk("t3_hour", 32'(hour_counter), 32'd17);
        chk("t3_bcd12", 32'(hour_bcd), 32'h05);
        chk("t3_pm", 32'(pm), 32'd1);
        mode_12h = 1'b0;
        step(1'b0, 1'b0, 5'd0);
        chk("t3_bcd24", 32'(hour_bcd), 32'h17);

        // Out-of-range request.
        ack_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'd24);
        step(1'b0, 1'b0, 5'd0);
        chk("t4_errs", 32'(err_cnt), 32'd1);
        chk("t4_acks", 32'(ack_cnt), 32'd0);
        chk("t4_hour", 32'(hour_counter), 32'd17);

        // Load beats a coincident tick.
        step(1'b1, 1'b1, 5'd23);
        chk("t5_hour", 32'(hour_counter), 32'd23);
        chk("t5_day", 32'(day), 32'd0);
        step(1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0);
        chk("t5_wrap", 32'(hour_counter), 32'd0);
        chk("t5_wrap_day", 32'(day), 32'd1);

        // Async reset mid-handshake.
        step(1'b0, 1'b1, 5'd9);
        step(1'b0, 1'b1, 5'd9);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_hour", 32'(hour_counter), 32'd0);
        chk("t6_bcd", 32'(hour_bcd), 32'h00);
        chk("t6_strobes", 32'({day, set_ack, set_err, pm}), 32'd0);
        m_hour = 0;
        m_wait = 1'b0;
        @(negedge clk);
        set_req = 1'b0;
        rst     = 1'b1;
        ack_cnt = 0;
        step(1'b0, 1'b1, 5'd4);
        chk("t6_reack", 32'(ack_cnt), 32'd1);
        step(1'b0, 1'b0, 5'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode_12h = ~mode_12h;
            step(($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0) ? ~set_req : set_req,
                 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
